// File: rtl/gate_truth_checker_pkg.sv
// Shared types and constants for the 2-input gate truth-table checker.
// Truth tables are indexed by the vector {a,b}: bit 0 = 00, bit 3 = 11.
package gate_truth_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  // Down-counter preload for a settle interval; 0 behaves as 1, above 15 clamps.
  function automatic logic [3:0] settle_load(int cycles);
    if (cycles <= 1)       return 4'd0;
    else if (cycles >= 15) return 4'd14;
    else                   return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/gate_truth_checker_settle_timer.sv
// 4-bit down-counter timing the settle interval; expired is high while the
// count is zero, so a preload of N-1 gives N cycles of SETTLE.
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       en,
  output logic       expired
);

  logic [3:0] cnt;

  // NOTE: sequential state is updated with <= so every register samples
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_value;
    end else if (en && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign expired = (cnt == 4'd0);

endmodule

// File: rtl/gate_truth_checker.sv
// Sequencer that walks {a,b} = 00..11 into a 2-input gate, samples dut_y
// after a settle interval and scores each vector against EXPECT.
module gate_truth_checker
  import gate_truth_checker_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXPECT        = TT_AND
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  localparam logic [3:0] LOAD_VALUE = settle_load(SETTLE_CYCLES);

  state_t     state, state_next;
  logic [1:0] idx;
  logic       tmr_load, tmr_en, tmr_expired;
  logic       mismatch;

  settle_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .load_value (LOAD_VALUE),
    .en         (tmr_en),
    .expired    (tmr_expired)
  );

  assign tmr_en   = (state == ST_SETTLE);
  assign mismatch = (dut_y != EXPECT[idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SETTLE;
          tmr_load   = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_expired) state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (idx == 2'd3) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_SETTLE;
          tmr_load   = 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // idx doubles as the driven vector, so {dut_a,dut_b} always equals idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= 2'd0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_mask <= 4'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            idx       <= 2'd0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_mask <= 4'd0;
          end
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            fail_mask[idx] <= 1'b1;
            err_count      <= err_count + 3'd1;
          end
          if (idx != 2'd3) idx <= idx + 2'd1;
        end
        ST_DONE: begin
          pass <= (err_count == 3'd0);
          idx  <= 2'd0;
        end
        default: ;
      endcase
    end
  end

  assign dut_a = idx[1];
  assign dut_b = idx[0];
  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_DONE);

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench: three checker instances (AND, NAND table, zero settle)
// each driving a NAND-built AND gate; a monitor scores every done pulse.
module tb_gate_truth_checker;
  import gate_truth_checker_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            stuck0 = 1'b0;
  logic [2:0]      start_v = '0;
  logic [2:0]      y_v, a_v, b_v, busy_v, done_v, pass_v;
  logic [2:0][2:0] err_v;
  logic [2:0][3:0] mask_v;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         inst;
    int         start_cyc;
    int         latency;
    logic       pss;
    logic [2:0] err;
    logic [3:0] mask;
  } exp_t;

  exp_t sb[$];
  int   pend_inst = -1;
  logic pend_pass = 1'b0;

  function automatic logic nand2(logic x, logic y);
    return ~(x & y);
  endfunction

  function automatic logic and_from_nand(logic x, logic y);
    return nand2(nand2(x, y), nand2(x, y));
  endfunction

  assign y_v[0] = stuck0 ? 1'b0 : and_from_nand(a_v[0], b_v[0]);
  assign y_v[1] = and_from_nand(a_v[1], b_v[1]);
  assign y_v[2] = and_from_nand(a_v[2], b_v[2]);

  gate_truth_checker #(.SETTLE_CYCLES(2), .EXPECT(TT_AND)) u_and (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .dut_y(y_v[0]),
    .dut_a(a_v[0]), .dut_b(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .err_count(err_v[0]), .fail_mask(mask_v[0]));

  gate_truth_checker #(.SETTLE_CYCLES(2), .EXPECT(TT_NAND)) u_nand (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .dut_y(y_v[1]),
    .dut_a(a_v[1]), .dut_b(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .err_count(err_v[1]), .fail_mask(mask_v[1]));

  gate_truth_checker #(.SETTLE_CYCLES(0), .EXPECT(TT_AND)) u_fast (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .dut_y(y_v[2]),
    .dut_a(a_v[2]), .dut_b(b_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .err_count(err_v[2]), .fail_mask(mask_v[2]));

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse, then checks pass next cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pend_inst >= 0) begin
        check("pass_after_done", int'(pass_v[pend_inst]), int'(pend_pass));
        pend_inst = -1;
      end
      for (int i = 0; i < 3; i++) begin
        if (done_v[i]) begin
          check("done_expected", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("done_instance", i, e.inst);
            check("done_latency", cyc - e.start_cyc, e.latency);
            check("err_count", int'(err_v[i]), int'(e.err));
            check("fail_mask", int'(mask_v[i]), int'(e.mask));
            pend_inst = i;
            pend_pass = e.pss;
          end
        end
      end
    end
  end

  task automatic push_exp(int inst, int st, int lat, logic pss, logic [2:0] err,
                          logic [3:0] mask);
    exp_t e;
    e.inst = inst; e.start_cyc = st; e.latency = lat;
    e.pss = pss; e.err = err; e.mask = mask;
    sb.push_back(e);
  endtask

  // Pulses start for one cycle; returns at cycle 1 of the run.
  task automatic issue(input int inst, input bit push, input int lat, input logic pss,
                       input logic [2:0] err, input logic [3:0] mask, output int e0);
    @(negedge clk);
    start_v[inst] = 1'b1;
    e0 = cyc;
    if (push) push_exp(inst, e0, lat, pss, err, mask);
    @(negedge clk);
    start_v[inst] = 1'b0;
  endtask

  task automatic at_cycle(int e0, int k);
    while (cyc < e0 + k) @(negedge clk);
  endtask

  task automatic wait_idle(int inst);
    bit finished = 1'b0;
    for (int n = 0; n < 80 && !finished; n++) begin
      @(negedge clk);
      if (!busy_v[inst] && sb.size() == 0) finished = 1'b1;
    end
    check("run_finished", int'(finished), 1);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(int inst);
    check("rst_busy", int'(busy_v[inst]), 0);
    check("rst_done", int'(done_v[inst]), 0);
    check("rst_vec", int'({a_v[inst], b_v[inst]}), 0);
    check("rst_pass", int'(pass_v[inst]), 0);
    check("rst_err", int'(err_v[inst]), 0);
    check("rst_mask", int'(mask_v[inst]), 0);
  endtask

  initial begin
    int e0;
    int vec_cyc[4];

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_reset_outputs(i);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // AND table against an AND gate: vectors at cycles 1,4,7,10, done at 13.
    vec_cyc = '{1, 4, 7, 10};
    issue(0, 1'b1, 13, 1'b1, 3'd0, 4'b0000, e0);
    check("busy_in_run", int'(busy_v[0]), 1);
    for (int v = 0; v < 4; v++) begin
      at_cycle(e0, vec_cyc[v]);
      check("vec_step", int'({a_v[0], b_v[0]}), v);
    end
    wait_idle(0);

    // NAND table against an AND gate: every vector mismatches.
    issue(1, 1'b1, 13, 1'b0, 3'd4, 4'b1111, e0);
    wait_idle(1);

    // Stuck-at-0 output: only vector 11 mismatches.
    stuck0 = 1'b1;
    issue(0, 1'b1, 13, 1'b0, 3'd1, 4'b1000, e0);
    check("pass_cleared_on_start", int'(pass_v[0]), 0);
    wait_idle(0);
    stuck0 = 1'b0;

    // start during SAMPLE (cycle 3) and DONE (cycle 13) is ignored.
    issue(0, 1'b1, 13, 1'b1, 3'd0, 4'b0000, e0);
    at_cycle(e0, 3);  start_v[0] = 1'b1;
    at_cycle(e0, 4);  start_v[0] = 1'b0;
    at_cycle(e0, 13); start_v[0] = 1'b1;
    at_cycle(e0, 14); start_v[0] = 1'b0;
    at_cycle(e0, 18);
    check("no_rerun_after_ignored_start", int'(busy_v[0]), 0);

    // start held high: second run starts after one IDLE cycle.
    @(negedge clk);
    start_v[0] = 1'b1;
    e0 = cyc;
    push_exp(0, e0, 13, 1'b1, 3'd0, 4'b0000);
    at_cycle(e0, 14);
    check("idle_gap_between_runs", int'(busy_v[0]), 0);
    push_exp(0, e0 + 14, 13, 1'b1, 3'd0, 4'b0000);
    at_cycle(e0, 15);
    start_v[0] = 1'b0;
    check("second_run_busy", int'(busy_v[0]), 1);
    wait_idle(0);

    // Reset at cycle 6 aborts the run with no done pulse.
    issue(0, 1'b0, 0, 1'b0, 3'd0, 4'b0000, e0);
    at_cycle(e0, 6);
    check("pre_abort_vec", int'({a_v[0], b_v[0]}), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_abort", int'(busy_v[0]), 0);
    issue(0, 1'b1, 13, 1'b1, 3'd0, 4'b0000, e0);
    wait_idle(0);

    // SETTLE_CYCLES=0 acts as 1: vectors at 1,3,5,7, done at 9.
    vec_cyc = '{1, 3, 5, 7};
    issue(2, 1'b1, 9, 1'b1, 3'd0, 4'b0000, e0);
    for (int v = 0; v < 4; v++) begin
      at_cycle(e0, vec_cyc[v]);
      check("fast_vec_step", int'({a_v[2], b_v[2]}), v);
    end
    wait_idle(2);

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cyc %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
